pixel_window_gen: RTL and testbench

PIXEL_WINDOW_GEN -- requirements
Module: pixel_window_gen

---
 rtl/pixel_window_gen.sv | 134 +++++++++++++
 tb/tb_pixel_window_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_gen.sv
// Streaming 2x2 window generator over a raster-order IMG_W x IMG_H frame.
// Optional feature: define WINDOW_COUNT_EN to add the win_cnt output.
module pixel_window_gen #(
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] pix_in,
   input  logic        pix_vld,
   output logic        pix_rdy,
   output logic [15:0] imgmn,
   output logic [15:0] imgm1n,
   output logic [15:0] imgmn1,
   output logic [15:0] imgm1n1,
   output logic        img_rdy,
   output logic        busy,
`ifdef WINDOW_COUNT_EN
   output logic [31:0] win_cnt,
`endif
   output logic        frame_done
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   logic [15:0]     left_q;
   logic [15:0]     top_q;
   logic [15:0]     mn_q, m1n_q, mn1_q, m1n1_q;
   logic            img_rdy_q;
   logic [15:0]     line_buf [IMG_W];
   logic            accept;
   logic            col_last;
   logic            row_last;
   logic            start_ok;

   assign col_last = (col_q == CW'(IMG_W - 1));
   assign row_last = (row_q == RW'(IMG_H - 1));
   assign start_ok = (state_q == StIdle) && start;
   assign accept   = pix_vld && pix_rdy;

   always_comb begin
      state_d    = state_q;
      pix_rdy    = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: if (start) state_d = StFill;
         StFill: begin
            pix_rdy = 1'b1;
            busy    = 1'b1;
            if (accept && col_last) state_d = StRun;
         end
         StRun: begin
            pix_rdy = 1'b1;
            busy    = 1'b1;
            if (accept && col_last && row_last) state_d = StDone;
         end
         StDone: begin
            frame_done = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         col_q     <= '0;
         row_q     <= '0;
         left_q    <= '0;
         top_q     <= '0;
         mn_q      <= '0;
         m1n_q     <= '0;
         mn1_q     <= '0;
         m1n1_q    <= '0;
         img_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_rdy_q <= 1'b0;
         if (start_ok) begin
            col_q <= '0;
            row_q <= '0;
         end else if (accept) begin
            // line_buf[col_q] still holds the previous row here; it is overwritten below
            left_q <= pix_in;
            top_q  <= line_buf[col_q];
            if (row_q != '0 && col_q != '0) begin
               mn_q      <= top_q;
               m1n_q     <= line_buf[col_q];
               mn1_q     <= left_q;
               m1n1_q    <= pix_in;
               img_rdy_q <= 1'b1;
            end
            if (col_last) begin
               col_q <= '0;
               row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   // Not reset: row 0 of every frame is written before any read uses it.
   always_ff @(posedge clk) begin
      if (accept) line_buf[col_q] <= pix_in;
   end

`ifdef WINDOW_COUNT_EN
   logic [31:0] win_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset || start_ok) win_cnt_q <= '0;
      else if (img_rdy_q)     win_cnt_q <= win_cnt_q + 32'd1;
   end

   assign win_cnt = win_cnt_q;
`endif

   assign imgmn   = mn_q;
   assign imgm1n  = m1n_q;
   assign imgmn1  = mn1_q;
   assign imgm1n1 = m1n1_q;
   assign img_rdy = img_rdy_q;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Directed bench for pixel_window_gen at IMG_W=4, IMG_H=3 with pixel value 16*r + c.
module tb_pixel_window_gen;

   localparam int W = 4;
   localparam int H = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] pix_in = '0;
   logic        pix_vld = 1'b0;
   logic        pix_rdy;
   logic [15:0] imgmn, imgm1n, imgmn1, imgm1n1;
   logic        img_rdy, busy, frame_done;
`ifdef WINDOW_COUNT_EN
   logic [31:0] win_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int nw;
   logic [15:0] e_mn, e_m1n, e_mn1, e_m1n1;

   pixel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pix_in     (pix_in),
      .pix_vld    (pix_vld),
      .pix_rdy    (pix_rdy),
      .imgmn      (imgmn),
      .imgm1n     (imgm1n),
      .imgmn1     (imgmn1),
      .imgm1n1    (imgm1n1),
      .img_rdy    (img_rdy),
      .busy       (busy),
`ifdef WINDOW_COUNT_EN
      .win_cnt    (win_cnt),
`endif
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_win(input string tag);
      chk({tag, "_mn"},   imgmn,   e_mn);
      chk({tag, "_m1n"},  imgm1n,  e_m1n);
      chk({tag, "_mn1"},  imgmn1,  e_mn1);
      chk({tag, "_m1n1"}, imgm1n1, e_m1n1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_pix_rdy"},    pix_rdy,    0);
      chk({tag, "_busy"},       busy,       0);
      chk({tag, "_img_rdy"},    img_rdy,    0);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   // Streams one frame; optional 3-cycle gap before pixel gap_at, start pulse with
   // pixel start_at, and early exit after pixel stop_after (-1 disables each).
   task automatic run_frame(input int gap_at, input int start_at, input int stop_after,
                            output int nwin);
      nwin = 0;
      for (int k = 0; k < W * H; k++) begin
         int r, c, n, m;
         r = k / W;
         c = k % W;
         if (k == gap_at) begin
            pix_vld = 1'b0;
            for (int g = 0; g < 3; g++) begin
               tick();
               chk("gap_img_rdy", img_rdy, 0);
               chk_win("gap_hold");
            end
         end
         chk("pix_rdy", pix_rdy, 1);
         pix_in  = 16'(16 * r + c);
         pix_vld = 1'b1;
         start   = (k == start_at);
         tick();
         start = 1'b0;
         if (r >= 1 && c >= 1) begin
            n = r - 1;
            m = c - 1;
            e_mn   = 16'(16 * n + m);
            e_m1n  = 16'(16 * n + m + 1);
            e_mn1  = 16'(16 * (n + 1) + m);
            e_m1n1 = 16'(16 * (n + 1) + m + 1);
            nwin++;
            chk("img_rdy_win", img_rdy, 1);
            chk_win("win");
         end else begin
            chk("img_rdy_none", img_rdy, 0);
         end
         chk("frame_done", frame_done, 32'(k == W * H - 1));
         chk("busy", busy, 32'(k != W * H - 1));
         if (k == stop_after) break;
      end
      pix_vld = 1'b0;
   endtask

   initial begin
      e_mn = '0; e_m1n = '0; e_mn1 = '0; e_m1n1 = '0;

      // Reset state
      tick();
      tick();
      chk_idle("rst");
      chk_win("rst");
      reset = 1'b1;
      tick();
      chk("idle_pix_rdy", pix_rdy, 0);

      // Frame 1: no gaps
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fill_busy", busy, 1);
      run_frame(-1, -1, -1, nw);
      chk("f1_windows", nw, 6);
      chk("f1_last_mn",   imgmn,   16'h0012);
      chk("f1_last_m1n",  imgm1n,  16'h0013);
      chk("f1_last_mn1",  imgmn1,  16'h0022);
      chk("f1_last_m1n1", imgm1n1, 16'h0023);
      chk("done_pix_rdy", pix_rdy, 0);
      tick();
      chk_idle("f1_after");
      chk_win("f1_hold");
`ifdef WINDOW_COUNT_EN
      chk("f1_win_cnt", win_cnt, 6);
`endif

      // Frame 2: stall mid-row 1, ignored start pulse in RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      run_frame(6, 9, -1, nw);
      chk("f2_windows", nw, 6);
      tick();
      chk_idle("f2_after");

      // Frame 3: reset after 6 pixels
      start = 1'b1;
      tick();
      start = 1'b0;
      run_frame(-1, -1, 5, nw);
      chk("f3_windows_before_abort", nw, 1);
      reset = 1'b0;
      tick();
      e_mn = '0; e_m1n = '0; e_mn1 = '0; e_m1n1 = '0;
      chk_idle("abort_rst");
      chk_win("abort_rst");
`ifdef WINDOW_COUNT_EN
      chk("abort_win_cnt", win_cnt, 0);
`endif
      reset = 1'b1;
      tick();
      chk("abort_idle_pix_rdy", pix_rdy, 0);

      // Frame 4: restart after reset
      start = 1'b1;
      tick();
      start = 1'b0;
      run_frame(-1, -1, -1, nw);
      chk("f4_windows", nw, 6);
      tick();
      chk_idle("f4_after");
`ifdef WINDOW_COUNT_EN
      chk("f4_win_cnt", win_cnt, 6);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_win_cnt", win_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
